// File: rtl/tdc_therm_encoder.sv
// tdc_therm_encoder: samples delay-line taps, detects the hit edge and emits a coarse/fine timestamp
module tdc_therm_encoder #(
  parameter int NTAPS    = 8,
  parameter int COARSE_W = 16,
  parameter int FINE_W   = $clog2(NTAPS + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NTAPS-1:0]    taps,
  input  logic                arm,
  output logic                ts_valid,
  input  logic                ts_ready,
  output logic [COARSE_W-1:0] ts_coarse,
  output logic [FINE_W-1:0]   ts_fine,
  output logic                overflow,
  output logic                busy
);
  typedef enum logic [1:0] {IDLE, ARMED, WAIT_CLEAR} state_t;
  state_t state, nxt;
  logic [COARSE_W-1:0] cnt, c1, c2;
  logic [NTAPS-1:0] s1, s2;
  logic p0, hit, take, room, clear;
  logic [FINE_W-1:0] pop;
  assign hit   = s2[0] && !p0;
  assign clear = s2 == '0;
  assign take  = state == ARMED && arm && hit;
  assign room  = !ts_valid || ts_ready;
  // popcount over every tap so isolated bubbles cannot shift the fine value
  always_comb begin
    pop = '0;
    for (int i = 0; i < NTAPS; i++) pop = pop + FINE_W'(s2[i]);
  end
  // next state: arm=0 only aborts ARMED; dead-time always waits for the line to clear
  always_comb begin
    nxt = state;
    case (state)
      IDLE:       nxt = arm ? ARMED : IDLE;
      ARMED:      nxt = !arm ? IDLE : hit ? WAIT_CLEAR : ARMED;
      WAIT_CLEAR: nxt = !clear ? WAIT_CLEAR : arm ? ARMED : IDLE;
      default:    nxt = IDLE;
    endcase
  end
  // two-flop capture of the asynchronous taps alongside the free-running coarse count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      s1  <= '0;
      s2  <= '0;
      c1  <= '0;
      c2  <= '0;
      p0  <= 1'b0;
    end else begin
      cnt <= cnt + COARSE_W'(1);
      s1  <= taps;
      c1  <= cnt;
      s2  <= s1;
      c2  <= c1;
      p0  <= s2[0];
    end
  end
  // sequencer and one-deep output register; a hit that finds it full is dropped and flagged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      ts_valid  <= 1'b0;
      ts_coarse <= '0;
      ts_fine   <= '0;
      overflow  <= 1'b0;
    end else begin
      state    <= nxt;
      busy     <= nxt == WAIT_CLEAR;
      overflow <= state == IDLE ? 1'b0 : overflow | (take && !room);
      if (take && room) begin
        ts_valid  <= 1'b1;
        ts_coarse <= c2;
        ts_fine   <= pop;
      end else if (ts_valid && ts_ready) begin
        ts_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_tdc_therm_encoder.sv
// tb_tdc_therm_encoder: directed vectors with hand-computed timestamps; COARSE_W=4 to reach the wrap quickly
module tb_tdc_therm_encoder;
  logic clk = 1'b0;
  logic rst_n, arm, ts_ready, ts_valid, overflow, busy;
  logic [7:0] taps;
  logic [3:0] ts_coarse, ts_fine;
  int vecs = 0, errs = 0;
  tdc_therm_encoder #(.NTAPS(8), .COARSE_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .taps(taps), .arm(arm), .ts_valid(ts_valid),
    .ts_ready(ts_ready), .ts_coarse(ts_coarse), .ts_fine(ts_fine),
    .overflow(overflow), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic pulse(input logic [7:0] v);
    taps = v;
    tick(1);
    taps = 8'h00;
  endtask
  initial begin
    rst_n = 1'b0; arm = 1'b1; taps = 8'h00; ts_ready = 1'b0;
    tick(2);
    chk("rst_valid", ts_valid, 0);
    chk("rst_coarse", ts_coarse, 0);
    chk("rst_fine", ts_fine, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    tick(5);
    pulse(8'h07);
    tick(1);
    chk("t1_latency", ts_valid, 0);
    chk("t1_busy_early", busy, 0);
    tick(1);
    chk("t1_valid", ts_valid, 1);
    chk("t1_coarse", ts_coarse, 5);
    chk("t1_fine", ts_fine, 3);
    chk("t1_busy", busy, 1);
    tick(1);
    chk("t1_busy_clear", busy, 0);
    chk("t1_hold", ts_valid, 1);
    ts_ready = 1'b1;
    tick(1);
    chk("t1_accept", ts_valid, 0);
    pulse(8'h0B);
    tick(2);
    chk("bubble_valid", ts_valid, 1);
    chk("bubble_coarse", ts_coarse, 10);
    chk("bubble_fine", ts_fine, 3);
    tick(1);
    pulse(8'hFF);
    tick(2);
    chk("full_fine", ts_fine, 8);
    chk("full_coarse", ts_coarse, 14);
    chk("full_ovf", overflow, 0);
    tick(1);
    ts_ready = 1'b0;
    pulse(8'h01);
    tick(2);
    chk("bp_first_valid", ts_valid, 1);
    chk("bp_first_coarse", ts_coarse, 2);
    tick(1);
    pulse(8'h03);
    tick(2);
    chk("bp_ovf", overflow, 1);
    chk("bp_keep_coarse", ts_coarse, 2);
    chk("bp_keep_fine", ts_fine, 1);
    chk("bp_busy", busy, 1);
    arm = 1'b0;
    tick(1);
    chk("bp_ovf_sticky", overflow, 1);
    tick(1);
    chk("bp_ovf_idle", overflow, 0);
    chk("bp_still_valid", ts_valid, 1);
    ts_ready = 1'b1;
    tick(1);
    chk("bp_drain", ts_valid, 0);
    pulse(8'h0F);
    tick(1);
    pulse(8'h0F);
    tick(3);
    chk("disarm_valid", ts_valid, 0);
    chk("disarm_busy", busy, 0);
    arm = 1'b1; ts_ready = 1'b0;
    tick(1);
    pulse(8'h01);
    tick(2);
    chk("sim_first_coarse", ts_coarse, 3);
    tick(1);
    pulse(8'h1F);
    tick(1);
    chk("sim_stable", ts_coarse, 3);
    ts_ready = 1'b1;
    tick(1);
    chk("sim_valid", ts_valid, 1);
    chk("sim_coarse", ts_coarse, 7);
    chk("sim_fine", ts_fine, 5);
    chk("sim_ovf", overflow, 0);
    tick(1);
    taps = 8'h03;
    tick(3);
    chk("wc_busy", busy, 1);
    chk("wc_coarse", ts_coarse, 11);
    chk("wc_fine", ts_fine, 2);
    arm = 1'b0;
    tick(2);
    chk("wc_hold_busy", busy, 1);
    taps = 8'h00;
    tick(2);
    chk("wc_drain_busy", busy, 1);
    tick(1);
    chk("wc_left", busy, 0);
    arm = 1'b1;
    tick(12);
    pulse(8'h01);
    tick(1);
    pulse(8'h03);
    chk("wrap_hi_coarse", ts_coarse, 15);
    chk("wrap_hi_fine", ts_fine, 1);
    tick(2);
    chk("wrap_lo_valid", ts_valid, 1);
    chk("wrap_lo_coarse", ts_coarse, 1);
    chk("wrap_lo_fine", ts_fine, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", ts_valid, 0);
    chk("arst_coarse", ts_coarse, 0);
    chk("arst_fine", ts_fine, 0);
    chk("arst_busy", busy, 0);
    arm = 1'b0;
    tick(1);
    rst_n = 1'b1;
    pulse(8'h07);
    tick(3);
    chk("post_rst_unarmed", ts_valid, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
